// File: rtl/axi_image_master.sv
// Loader/readback engine: streams image words into memory over AXI-lite writes,
// or reads a block back out onto an output stream.
module axi_image_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    IDLE, W_FETCH, W_ISSUE, R_ADDR, R_DATA, R_OUT, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  idx;
  logic              aw_pend;
  logic              w_pend;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdata_q;

  logic s_fire;
  logic aw_done;
  logic w_done;
  logic word_issued;
  logic word_read;
  logic last_word;

  assign s_fire      = (state == W_FETCH) && s_valid;
  // A channel with nothing pending counts as already complete.
  assign aw_done     = !aw_pend || axi_awready;
  assign w_done      = !w_pend || axi_wready;
  assign word_issued = (state == W_ISSUE) && aw_done && w_done;
  assign word_read   = (state == R_OUT) && m_ready;
  assign last_word   = (idx + CNT_W'(1)) == num_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_next = DONE;
          end else if (mode) begin
            state_next = R_ADDR;
          end else begin
            state_next = W_FETCH;
          end
        end
      end
      W_FETCH: if (s_valid) state_next = W_ISSUE;
      W_ISSUE: if (word_issued) state_next = last_word ? DONE : W_FETCH;
      R_ADDR:  if (axi_arready) state_next = R_DATA;
      R_DATA:  if (axi_rvalid) state_next = R_OUT;
      R_OUT:   if (m_ready) state_next = last_word ? DONE : R_ADDR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // addr_q always holds the address of the word in flight, so it serves both AW and AR.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      num_q   <= '0;
      idx     <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      wdata_q <= '0;
      mdata_q <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        addr_q <= base_addr;
        num_q  <= num_words;
        idx    <= '0;
      end
      if (s_fire) begin
        wdata_q <= s_data;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end
      if (state == W_ISSUE) begin
        if (aw_pend && axi_awready) aw_pend <= 1'b0;
        if (w_pend && axi_wready) w_pend <= 1'b0;
      end
      if (word_issued || word_read) begin
        idx    <= idx + CNT_W'(1);
        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
      end
      if ((state == R_DATA) && axi_rvalid) begin
        mdata_q <= axi_rdata;
      end
    end
  end

  always_comb begin
    s_ready     = (state == W_FETCH);
    axi_arvalid = (state == R_ADDR);
    axi_rready  = (state == R_DATA);
    m_valid     = (state == R_OUT);
    done        = (state == DONE);
    busy        = (state != IDLE) && (state != DONE);
  end

  assign axi_awvalid = aw_pend;
  assign axi_wvalid  = w_pend;
  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_wdata   = wdata_q;
  assign m_data      = mdata_q;
  assign word_count  = idx;

endmodule
